// File: rtl/flash_arb_pkg.sv
// Shared definitions for the flash access arbiter: FSM state encoding,
// requester indices and the default WAIT timeout.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT     = 2'd2,
        ST_COMPLETE = 2'd3
    } arb_state_t;

    // Bit positions in req/cmd_wr/gnt/done; last_served stores the index.
    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    localparam int TIMEOUT_CYC_DEFAULT = 1024;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. A sole requester always wins; on a tie the
// requester that was not served last wins. Purely combinational.
module rr_arbiter2
    import flash_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] winner
);

    // Pick A when it is alone or when B had the previous turn, else B if asking
    always_comb begin
        winner = 2'b00;
        if (req[REQ_A] && (!req[REQ_B] || (last_served == 1'(REQ_B)))) begin
            winner[REQ_A] = 1'b1;
        end else if (req[REQ_B]) begin
            winner[REQ_B] = 1'b1;
        end
    end

endmodule

// File: rtl/flash_access_arbiter.sv
// Arbitrates two requesters (A = host/UART, B = scoreboard) onto a single
// flash manager port. One access at a time: latch fields, strobe fl_trg,
// wait for fl_tx_trig, pulse done.
// Optional build macro FLASH_ARB_TIMEOUT_EN: bounds the WAIT state to
// TIMEOUT_CYC cycles and reports an abort on timeout_err.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | no access in flight; arbitrate and latch winner's fields
// ST_ISSUE    | one-cycle fl_trg to the flash manager, gnt raised
// ST_WAIT     | waiting for fl_tx_trig (or timeout when enabled)
// ST_COMPLETE | one-cycle done pulse to the winner, gnt drops on exit
module flash_access_arbiter
    import flash_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        CLK_50MHZ,
    input  logic        RST,
    input  logic [1:0]  req,
    input  logic [1:0]  cmd_wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [7:0]  rdata,
    output logic        timeout_err,
    output logic        fl_trg,
    output logic        fl_cmd,
    output logic [7:0]  fl_addr,
    output logic [7:0]  fl_wdata,
    input  logic        fl_tx_trig,
    input  logic [7:0]  fl_rdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic [1:0] winner;
    logic [1:0] win_q;
    logic       last_served;
    logic       sel_b;
    logic       wait_expired;

    rr_arbiter2 u_rr_arbiter2 (
        .req         (req),
        .last_served (last_served),
        .winner      (winner)
    );

    assign sel_b = winner[REQ_B];

    // State register
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the COMPLETE->IDLE->ISSUE path keeps fl_trg at least
    // three cycles behind the previous fl_tx_trig
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (|req) state_nxt = ST_ISSUE;
            ST_ISSUE:    state_nxt = ST_WAIT;
            ST_WAIT:     if (fl_tx_trig || wait_expired) state_nxt = ST_COMPLETE;
            ST_COMPLETE: state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state and the latched winner
    always_comb begin
        gnt    = 2'b00;
        done   = 2'b00;
        fl_trg = 1'b0;
        case (state)
            ST_ISSUE: begin
                gnt    = win_q;
                fl_trg = 1'b1;
            end
            ST_WAIT: begin
                gnt = win_q;
            end
            ST_COMPLETE: begin
                gnt  = win_q;
                done = win_q;
            end
            default: ;
        endcase
    end

    // Latch the winner and its access fields on the way into ISSUE; capture
    // flash read data (reads and writes alike) only while waiting
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            win_q       <= 2'b00;
            last_served <= 1'(REQ_B);
            fl_cmd      <= 1'b0;
            fl_addr     <= 8'h00;
            fl_wdata    <= 8'h00;
            rdata       <= 8'h00;
        end else begin
            if ((state == ST_IDLE) && (|req)) begin
                win_q       <= winner;
                last_served <= sel_b;
                fl_cmd      <= sel_b ? cmd_wr[REQ_B] : cmd_wr[REQ_A];
                fl_addr     <= sel_b ? addr[15:8]    : addr[7:0];
                fl_wdata    <= sel_b ? wdata[15:8]   : wdata[7:0];
            end
            if ((state == ST_WAIT) && fl_tx_trig) begin
                rdata <= fl_rdata;
            end
        end
    end

`ifdef FLASH_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             abort_q;

    // Count WAIT cycles from zero; remember whether WAIT ended by expiry
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            wait_cnt <= '0;
            abort_q  <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            abort_q <= (state == ST_WAIT) && !fl_tx_trig && wait_expired;
        end
    end

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout_err  = (state == ST_COMPLETE) && abort_q;
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule
